// File: rtl/ifmap_decompressor_pkg.sv
// ifmap_decompressor_pkg
//   Types and constants shared by the ifmap decompressor and the ifmap buffer.
//   DECOMRPESS_FIFO_PACKET : one dense 8-lane group handed to the ifmap buffer.
//   state_e                : decompressor control states.
//   countones              : popcount of a mask byte.
package ifmap_decompressor_pkg;

    localparam int IFMP_DATA_SIZE = 8;
    localparam int STG_DEPTH      = 16;
    localparam int COMP_WORD_W    = 64;

    typedef struct packed {
        logic                                packet_valid;
        logic [IFMP_DATA_SIZE-1:0]           valid_mask;
        logic [IFMP_DATA_SIZE-1:0][7:0]      data;
    } DECOMRPESS_FIFO_PACKET;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [3:0] countones(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/ifmap_decompressor_mask.sv
// mask_expander
//   Combinational expansion of one bitmask group sitting at the front of the
//   staging buffer.
//   stg_i  : staging bytes 0..8 (byte 0 is the mask byte M)
//   lane_o : dense lanes, lane i = M[i] ? payload byte 1+popcount(M[i-1:0]) : 0
//   used_o : bytes consumed by the group, 1+popcount(M)
module mask_expander
    import ifmap_decompressor_pkg::*;
(
    input  logic [8:0][7:0] stg_i,
    output logic [7:0][7:0] lane_o,
    output logic [3:0]      used_o
);

    logic [7:0] mask;
    logic [7:0] below;
    logic [3:0] idx;

    assign mask = stg_i[0];

    always_comb begin
        used_o = 4'd1 + countones(mask);
        lane_o = '0;
        below  = 8'h00;
        idx    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            // payload bytes for lanes below i come first in the stream
            below = mask & ((8'd1 << i) - 8'd1);
            idx   = 4'd1 + countones(below);
            lane_o[i] = mask[i] ? stg_i[idx] : 8'h00;
        end
    end

endmodule

// File: rtl/ifmap_decompressor.sv
// ifmap_decompressor
//   Fetches bitmask-compressed ifmap words from the global buffer, expands
//   each mask group to a dense 8-byte packet and hands packets to the ifmap
//   buffer under its request/ack handshake.
//   start/base_addr/comp_words/elem_total : run setup (start aborts any run)
//   gb_rd_req/gb_rd_addr/gb_rd_valid/gb_rd_data : global-buffer read port
//   ifmap_req/decompressor_ack/decompressed_fifo_packet : packet handshake
//   done : pulse on the ack of the last packet; err : sticky underflow
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no run active (after reset, done, or underflow)
// ST_RUN   | fetching words and decoding groups
// ST_DRAIN | last packet loaded, waiting for its ack
module ifmap_decompressor
    import ifmap_decompressor_pkg::*;
#(
    parameter int GB_ADDR_W = 16,
    parameter int ELEM_W    = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [GB_ADDR_W-1:0]   base_addr,
    input  logic [GB_ADDR_W-1:0]   comp_words,
    input  logic [ELEM_W-1:0]      elem_total,
    output logic                   gb_rd_req,
    output logic [GB_ADDR_W-1:0]   gb_rd_addr,
    input  logic                   gb_rd_valid,
    input  logic [COMP_WORD_W-1:0] gb_rd_data,
    input  logic                   ifmap_req,
    output logic                   decompressor_ack,
    output DECOMRPESS_FIFO_PACKET  decompressed_fifo_packet,
    output logic                   done,
    output logic                   err
);

    state_e                    state_q;
    logic [GB_ADDR_W-1:0]      base_q, base_d, words_q, words_d, issued_q, issued_d;
    logic [ELEM_W-1:0]         remaining_q, remaining_d, take, rem_after;
    logic [STG_DEPTH-1:0][7:0] stg_q, stg_d, stg_shift;
    logic [4:0]                level_q, level_d, lvl_shift;
    logic                      pend_q, pend_d, stale_q, stale_d, err_q, err_d;
    DECOMRPESS_FIFO_PACKET     pkt_q, pkt_d;
    logic [7:0][7:0]           lanes;
    logic [3:0]                used;
    logic [7:0]                vmask;
    logic                      fetch, ack, beat, stg_enough, decode, underflow, last_load;

    mask_expander u_mask_expander (
        .stg_i  (stg_q[8:0]),
        .lane_o (lanes),
        .used_o (used)
    );

    assign ack        = ifmap_req & pkt_q.packet_valid;
    assign fetch      = (state_q == ST_RUN) & ~pend_q & (level_q <= 5'd8) & (issued_q < words_q);
    // a beat for a read issued before the latest start is dropped
    assign beat       = gb_rd_valid & pend_q & ~stale_q;
    assign stg_enough = (level_q != 5'd0) & ({1'b0, used} <= level_q);
    assign decode     = (state_q == ST_RUN) & stg_enough & (~pkt_q.packet_valid | ack)
                        & (remaining_q != '0);
    assign underflow  = (state_q == ST_RUN) & (issued_q == words_q) & ~pend_q & ~stg_enough
                        & (remaining_q != '0);
    assign take       = (remaining_q >= ELEM_W'(IFMP_DATA_SIZE)) ? ELEM_W'(IFMP_DATA_SIZE)
                                                                 : remaining_q;
    assign vmask      = (remaining_q >= ELEM_W'(IFMP_DATA_SIZE)) ? 8'hFF
                                                                 : ((8'd1 << remaining_q[2:0]) - 8'd1);
    assign rem_after  = remaining_q - take;
    assign last_load  = decode & (rem_after == '0);

    assign gb_rd_req                = fetch;
    assign gb_rd_addr               = base_q + issued_q;
    assign decompressor_ack         = ack;
    assign decompressed_fifo_packet = pkt_q;
    assign done                     = (state_q == ST_DRAIN) & ack & ~start;
    assign err                      = err_q;

    always_comb begin
        // shift out the decoded group first, then append the new word behind it
        stg_shift   = stg_q >> {(decode ? used : 4'd0), 3'b000};
        lvl_shift   = level_q - (decode ? {1'b0, used} : 5'd0);
        stg_d       = stg_shift;
        level_d     = lvl_shift;
        if (beat) begin
            stg_d   = stg_shift | ({{(STG_DEPTH*8-COMP_WORD_W){1'b0}}, gb_rd_data}
                                   << {lvl_shift, 3'b000});
            level_d = lvl_shift + 5'd8;
        end
        base_d      = base_q;
        words_d     = words_q;
        issued_d    = issued_q + {{(GB_ADDR_W-1){1'b0}}, fetch};
        remaining_d = decode ? rem_after : remaining_q;
        pend_d      = fetch ? 1'b1 : (gb_rd_valid ? 1'b0 : pend_q);
        stale_d     = gb_rd_valid ? 1'b0 : stale_q;
        err_d       = err_q | underflow;
        pkt_d       = pkt_q;
        if (decode) begin
            pkt_d.packet_valid = 1'b1;
            pkt_d.valid_mask   = vmask;
            pkt_d.data         = lanes;
        end else if (ack) begin
            pkt_d = '0;
        end
        if (start) begin
            stg_d       = '0;
            level_d     = 5'd0;
            pkt_d       = '0;
            base_d      = base_addr;
            words_d     = comp_words;
            issued_d    = '0;
            remaining_d = elem_total;
            err_d       = 1'b0;
            // anything still in flight belongs to the aborted run
            pend_d      = (pend_q & ~gb_rd_valid) | fetch;
            stale_d     = pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else if (start) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (underflow)      state_q <= ST_IDLE;
                    else if (last_load) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (ack) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            words_q     <= '0;
            issued_q    <= '0;
            remaining_q <= '0;
            stg_q       <= '0;
            level_q     <= 5'd0;
            pend_q      <= 1'b0;
            stale_q     <= 1'b0;
            err_q       <= 1'b0;
            pkt_q       <= '0;
        end else begin
            base_q      <= base_d;
            words_q     <= words_d;
            issued_q    <= issued_d;
            remaining_q <= remaining_d;
            stg_q       <= stg_d;
            level_q     <= level_d;
            pend_q      <= pend_d;
            stale_q     <= stale_d;
            err_q       <= err_d;
            pkt_q       <= pkt_d;
        end
    end

endmodule
